// File: rtl/park_pkg.sv
// Shared types and sizes for the parking-lot entry allocator.
package park_pkg;

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned SLOT_W    = 3;
  localparam int unsigned COUNT_W   = 4;
  localparam int unsigned STAT_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GATE  = 2'd2
  } state_t;

  // Number of zero bits in an occupancy map, i.e. free slots.
  function automatic logic [COUNT_W-1:0] free_slots(input logic [NUM_SLOTS-1:0] map);
    logic [COUNT_W-1:0] n;
    n = COUNT_W'(NUM_SLOTS);
    for (int i = 0; i < int'(NUM_SLOTS); i++) begin
      n = n - COUNT_W'(map[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/park_entry_allocator_if.sv
// Entry/exit handshake bundle for park_entry_allocator.
// PARK_STATS_EN adds the total_entries / total_rejects statistics outputs.
interface park_entry_allocator_if;
  import park_pkg::*;

  logic                 entry_req;
  logic                 exit_valid;
  logic [SLOT_W-1:0]    exit_number;
  logic                 entry_grant;
  logic                 entry_reject;
  logic [SLOT_W-1:0]    park_number;
  logic [NUM_SLOTS-1:0] park_location;
  logic [COUNT_W-1:0]   free_count;
  logic                 full;
  logic                 exit_error;
  logic                 entry_gate;
`ifdef PARK_STATS_EN
  logic [STAT_W-1:0]    total_entries;
  logic [STAT_W-1:0]    total_rejects;

  modport master (
    output entry_req, exit_valid, exit_number,
    input  entry_grant, entry_reject, park_number, park_location,
           free_count, full, exit_error, entry_gate,
           total_entries, total_rejects
  );

  modport slave (
    input  entry_req, exit_valid, exit_number,
    output entry_grant, entry_reject, park_number, park_location,
           free_count, full, exit_error, entry_gate,
           total_entries, total_rejects
  );
`else
  modport master (
    output entry_req, exit_valid, exit_number,
    input  entry_grant, entry_reject, park_number, park_location,
           free_count, full, exit_error, entry_gate
  );

  modport slave (
    input  entry_req, exit_valid, exit_number,
    output entry_grant, entry_reject, park_number, park_location,
           free_count, full, exit_error, entry_gate
  );
`endif

endinterface

// File: rtl/park_free_slot_finder.sv
// Combinational priority encoder: lowest-index free (zero) slot of the occupancy map.
module park_free_slot_finder
  import park_pkg::*;
(
  input  logic [NUM_SLOTS-1:0] map,
  output logic [SLOT_W-1:0]    free_idx_c,
  output logic                 found_c
);

  // Scan from the top down so the last hit is the lowest free index.
  always_comb begin
    free_idx_c = '0;
    found_c    = 1'b0;
    for (int i = int'(NUM_SLOTS) - 1; i >= 0; i--) begin
      if (!map[i]) begin
        free_idx_c = SLOT_W'(i);
        found_c    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/park_entry_allocator.sv
// Parking-lot entry allocator: grants the lowest free slot to a waiting car,
// opens the barrier for GATE_CYCLES cycles, and tracks exits.
// Optional macro PARK_STATS_EN adds saturating grant/reject counters.
module park_entry_allocator
  import park_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = 4
) (
  input logic                  clk,
  input logic                  rst,
  park_entry_allocator_if.slave bus
);

  localparam int unsigned CNT_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     gate_cnt;
  logic [SLOT_W-1:0]    free_idx;
  logic                 free_found;
  logic                 alloc;
  logic                 reject;
  logic                 exit_hit;
  logic                 exit_miss;
  logic [NUM_SLOTS-1:0] loc_next;
  logic [COUNT_W-1:0]   free_next;

  park_free_slot_finder u_finder (
    .map        (bus.park_location),
    .free_idx_c (free_idx),
    .found_c    (free_found)
  );

  // Next state, allocation/reject decision and next occupancy (pre-exit map drives allocation).
  always_comb begin
    state_next = state;
    alloc      = 1'b0;
    reject     = 1'b0;
    exit_hit   = bus.exit_valid & bus.park_location[bus.exit_number];
    exit_miss  = bus.exit_valid & ~bus.park_location[bus.exit_number];
    loc_next   = bus.park_location;
    case (state)
      IDLE: begin
        if (bus.entry_req) begin
          if (bus.full || !free_found) begin
            reject = 1'b1;
          end else begin
            alloc      = 1'b1;
            state_next = GRANT;
          end
        end
      end
      GRANT:   state_next = GATE;
      GATE:    if (gate_cnt == CNT_W'(GATE_CYCLES - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (exit_hit) loc_next[bus.exit_number] = 1'b0;
    if (alloc)    loc_next[free_idx]        = 1'b1;
    free_next = free_slots(loc_next);
  end

  // FSM, occupancy map and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      gate_cnt          <= '0;
      bus.park_location <= '0;
      bus.park_number   <= '0;
      bus.free_count    <= COUNT_W'(NUM_SLOTS);
      bus.full          <= 1'b0;
      bus.entry_grant   <= 1'b0;
      bus.entry_reject  <= 1'b0;
      bus.entry_gate    <= 1'b0;
      bus.exit_error    <= 1'b0;
    end else begin
      state             <= state_next;
      gate_cnt          <= (state == GATE && state_next == GATE) ? gate_cnt + CNT_W'(1) : '0;
      bus.park_location <= loc_next;
      bus.free_count    <= free_next;
      bus.full          <= (free_next == '0);
      bus.entry_grant   <= alloc;
      bus.entry_reject  <= reject;
      bus.entry_gate    <= (state_next == GATE);
      bus.exit_error    <= exit_miss;
      if (alloc) bus.park_number <= free_idx;
    end
  end

`ifdef PARK_STATS_EN
  // Saturating totals, updated on the same edge that raises grant/reject.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.total_entries <= '0;
      bus.total_rejects <= '0;
    end else begin
      if (alloc && bus.total_entries != '1)
        bus.total_entries <= bus.total_entries + STAT_W'(1);
      if (reject && bus.total_rejects != '1)
        bus.total_rejects <= bus.total_rejects + STAT_W'(1);
    end
  end
`endif

endmodule

// File: doc/park_entry_allocator.md
PARK_ENTRY_ALLOCATOR -- requirements
Module: park_entry_allocator

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 4, meaning the number of cycles entry_gate stays high after a grant.
REQ-002 The block SHALL have one clock, clk, with all state updated on its rising edge.
REQ-003 The block SHALL have a reset port rst, input, width 1: synchronous, active-high reset.
REQ-004 The block SHALL have port entry_req, input, width 1: a car is waiting at the entry; level, sampled each cycle.
REQ-005 The block SHALL have port exit_valid, input, width 1: single-cycle strobe qualifying exit_number.
REQ-006 The block SHALL have port exit_number, input, width 3: slot being vacated.
REQ-007 The block SHALL have port entry_grant, output, width 1: one-cycle pulse; park_number is valid.
REQ-008 The block SHALL have port entry_reject, output, width 1: one-cycle pulse; the lot is full.
REQ-009 The block SHALL have port park_number, output, width 3: assigned slot, held until the next grant.
REQ-010 The block SHALL have port park_location, output, width 8: occupancy map; bit i set means slot i is occupied.
REQ-011 The block SHALL have ports free_count (output, width 4, 0..8), full (output, width 1) and exit_error (output, width 1, one-cycle pulse).
REQ-012 The block SHALL have port entry_gate, output, width 1: barrier-open command.

Function
REQ-013 The FSM SHALL have states IDLE, GRANT and GATE, encoded in 2 bits.
- IDLE -> GRANT: entry_req=1 and full=0.
- GRANT -> GATE: unconditional, after one cycle.
- GATE -> IDLE: when the gate counter reaches GATE_CYCLES-1.
REQ-014 On IDLE -> GRANT, the block SHALL select the lowest-index zero bit of park_location, register it into park_number, and set that bit.
REQ-015 entry_grant SHALL pulse in the cycle the FSM is in GRANT, giving a latency of one cycle from the sampled entry_req.
REQ-016 entry_gate SHALL be high throughout GATE, for exactly GATE_CYCLES cycles, and low otherwise.
REQ-017 When the FSM is in IDLE with entry_req=1 and full=1, entry_reject SHALL pulse, the FSM SHALL stay in IDLE, and the block SHALL re-evaluate every cycle while entry_req is held.
REQ-018 While the FSM is in GRANT or GATE, entry_req SHALL be ignored, so at most one car is admitted per gate cycle.
REQ-019 On exit_valid with park_location[exit_number]=1, the block SHALL clear that bit on the next edge, in any FSM state.
REQ-020 On exit_valid with park_location[exit_number]=0, the block SHALL pulse exit_error and leave park_location unchanged.
REQ-021 For an exit and an allocation in the same cycle, both updates SHALL apply.
REQ-022 Allocation SHALL use the pre-exit occupancy, so a slot freed in cycle N is allocatable from cycle N+1.
REQ-023 When the lot is full and an exit coincides with entry_req, the block SHALL reject in that cycle and grant in the next.
REQ-024 free_count SHALL equal 8 minus the popcount of park_location.
REQ-025 full SHALL equal (free_count==0).
REQ-026 free_count and full SHALL be registered, consistent with park_location in the same cycle.

Reset
REQ-027 Reset SHALL drive FSM=IDLE, park_location=8'h00, park_number=3'd0, free_count=4'd8, and the gate counter to 0.
REQ-028 Reset SHALL drive full, entry_grant, entry_reject, entry_gate and exit_error to 0.
REQ-029 Reset during GRANT or GATE SHALL abort immediately, drop entry_gate, and discard the allocation.

Configuration
REQ-030 With macro PARK_STATS_EN defined, the block SHALL add outputs total_entries[15:0] and total_rejects[15:0].
- Each counter saturates at 16'hFFFF.
- Each counter resets to 0.
- total_entries increments on entry_grant; total_rejects increments on entry_reject.
REQ-031 Without PARK_STATS_EN, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-032 Package park_pkg SHALL hold:
- the state typedef;
- NUM_SLOTS=8;
- SLOT_W=3;
- COUNT_W=4.
REQ-033 The lowest-free-slot priority encoder SHALL be sub-module park_free_slot_finder, which is purely combinational: 8-bit map in, 3-bit index plus found flag out.

Verification
REQ-034 After reset, holding entry_req for 8 gate cycles with GATE_CYCLES=4 SHALL produce grants on park_number 0..7, then park_location=8'hFF, full=1 and free_count=0.
REQ-035 With the lot full and entry_req=1, the block SHALL give entry_reject every cycle and no grant; an exit_valid on slot 5 SHALL be followed by a grant with park_number=5 one cycle later.
REQ-036 With park_location=8'h0F, exit_valid on slot 6 SHALL pulse exit_error with park_location still 8'h0F.
REQ-037 With park_location=8'h03, an exit of slot 0 coinciding with entry_req SHALL give a grant with park_number=2, then park_location=8'h06.
REQ-038 Asserting rst mid-GATE SHALL drop entry_gate on the next edge and restore park_location=8'h00 and free_count=8.
REQ-039 With PARK_STATS_EN, 10 requests on an empty lot SHALL give total_entries=8 and total_rejects equal to the number of reject cycles observed.
